fifo_ext: RTL and testbench
===========================

// Module: fifo_ext
// PURPOSE
//   Synchronous single-clock FIFO, next generation of the team FIFO.
//   Adds arbitrary (non-power-of-2) depth, almost-full/almost-empty thresholds,
//   enqueue-on-full when a dequeue happens in the same cycle, sticky overflow/underflow
//   error flags and an occupancy high-water mark.
//   Sits between producer/consumer blocks (UART, SPI, bus bridges) as the standard elastic buffer.
// PARAMETERS
//   p_WORD_LEN      8  data word width in bits (>=1)
//   p_FIFO_SIZE     8  depth in words (>=2, any integer)
//   p_AFULL_THRESH  6  o_almost_full asserted when occupancy >= this (1..p_FIFO_SIZE)
//   p_AEMPTY_THRESH 2  o_almost_empty asserted when occupancy <= this (0..p_FIFO_SIZE-1)
//   localparams: AW = max(1,$clog2(p_FIFO_SIZE)); LW = $clog2(p_FIFO_SIZE+1)
// PORTS
//   i_clk           in   1   clock, all state updates on rising edge
//   i_reset         in   1   reset, synchronous, active-high
//   i_enq_data      in   WL  data to enqueue
//   i_enq_en        in   1   enqueue request
//   o_enq_rdy       out  1   enqueue will be accepted this cycle
//   o_out_data      out  WL  head-of-queue word (first-word fall-through)
//   i_deq_en        in   1   dequeue request
//   o_deq_rdy       out  1   dequeue will be accepted this cycle (= !o_empty)
//   o_full          out  1   occupancy == p_FIFO_SIZE
//   o_empty         out  1   occupancy == 0
//   o_almost_full   out  1   occupancy >= p_AFULL_THRESH
//   o_almost_empty  out  1   occupancy <= p_AEMPTY_THRESH
//   o_len           out  LW  current occupancy, 0..p_FIFO_SIZE
//   o_max_len       out  LW  high-water mark of occupancy since reset/clear
//   o_overflow      out  1   sticky: enqueue request rejected
//   o_underflow     out  1   sticky: dequeue request rejected
//   i_clr_err       in   1   clears o_overflow, o_underflow, reloads o_max_len
// BEHAVIOUR
// - State: head addr, tail addr (each 0..p_FIFO_SIZE-1, wrap to 0 after SIZE-1), occupancy reg.
// - Status outputs decode the registered occupancy combinationally.
// - deq_acc = i_deq_en & !o_empty. No bypass: an empty FIFO never dequeues, even with a
//   simultaneous enqueue.
// - o_enq_rdy = !o_full | i_deq_en (combinational path from i_deq_en); enq_acc = i_enq_en & o_enq_rdy.
// - enq_acc: mem[head] <= i_enq_data, head advances. deq_acc: tail advances.
//   Occupancy += enq_acc - deq_acc (both accepted -> unchanged).
// - Full & enq & deq same cycle: both accepted, len stays p_FIFO_SIZE, oldest word leaves.
// - o_out_data = mem[tail] combinationally, zero latency; when o_empty it is all-ones.
//   Written word is visible at o_out_data the cycle after enq_acc.
// - o_overflow sets on (i_enq_en & !enq_acc). o_underflow sets on (i_deq_en & o_empty).
//   Both are sticky until i_clr_err; set wins over clear in the same cycle.
// - o_max_len updates to next occupancy when it exceeds the current value.
//   i_clr_err loads the next occupancy.
// - Reset (any cycle, overrides all requests; memory contents not reset):
//   head=tail=len=0, o_max_len=0, o_overflow=o_underflow=0.
//   Next cycle: o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0,
//   o_enq_rdy=1, o_deq_rdy=0, o_out_data=all-ones.
// - Reset mid-operation discards queued data; enqueue/dequeue during the reset cycle is ignored.
// TESTING (defaults WL=8, SIZE=8, AF=6, AE=2, plus one run with SIZE=5)
// 1. Reset, then enqueue 0x01..0x08 on consecutive cycles -> o_len 1..8, o_almost_empty drops at len=3,
//    o_almost_full rises at len=6, o_full=1 at len=8, o_max_len=8, o_out_data=0x01.
// 2. Full, then enq 0xAA with no deq -> rejected, o_overflow=1, len=8.
//    Full, enq 0xBB with deq -> both accepted, len=8, 0xBB is 8th word out.
// 3. Empty, then deq alone -> o_underflow=1, o_out_data=0xFF.
//    Empty, enq 0x5A with deq -> enq only, len=1, o_underflow=1.
// 4. SIZE=5: 20 enq/deq cycles with occupancy 0..5 -> head/tail wrap at 4->0,
//    output order matches input order, o_full exactly at len=5.
// 5. i_clr_err with len=3 -> flags clear, o_max_len=3; i_clr_err with overflow same cycle -> o_overflow stays 1.
// 6. Reset asserted at len=4 with enq+deq active -> next cycle len=0, o_empty=1, o_max_len=0, flags 0.

Source files
------------

// File: rtl/fifo_ext.sv
// fifo_ext: single-clock elastic buffer with arbitrary depth, almost-full /
// almost-empty thresholds, enqueue-on-full when a dequeue happens in the same cycle,
// sticky overflow/underflow flags and an occupancy high-water mark.
module fifo_ext #(
    parameter int p_WORD_LEN      = 8,
    parameter int p_FIFO_SIZE     = 8,
    parameter int p_AFULL_THRESH  = 6,
    parameter int p_AEMPTY_THRESH = 2,
    localparam int AW = (p_FIFO_SIZE > 2) ? $clog2(p_FIFO_SIZE) : 1,
    localparam int LW = $clog2(p_FIFO_SIZE + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [p_WORD_LEN-1:0] i_enq_data,
    input  logic                  i_enq_en,
    output logic                  o_enq_rdy,
    output logic [p_WORD_LEN-1:0] o_out_data,
    input  logic                  i_deq_en,
    output logic                  o_deq_rdy,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [LW-1:0]         o_len,
    output logic [LW-1:0]         o_max_len,
    output logic                  o_overflow,
    output logic                  o_underflow,
    input  logic                  i_clr_err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(p_FIFO_SIZE - 1);
    localparam logic [LW-1:0] SIZE_L    = LW'(p_FIFO_SIZE);
    localparam logic [LW-1:0] AFULL_L   = LW'(p_AFULL_THRESH);
    localparam logic [LW-1:0] AEMPTY_L  = LW'(p_AEMPTY_THRESH);

    logic [p_WORD_LEN-1:0] mem [p_FIFO_SIZE];
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [LW-1:0]         len;
    logic [LW-1:0]         len_nxt;
    logic                  enq_acc;
    logic                  deq_acc;

    // Status decode of the registered occupancy and request acceptance.
    always_comb begin
        o_full         = (len == SIZE_L);
        o_empty        = (len == '0);
        o_almost_full  = (len >= AFULL_L);
        o_almost_empty = (len <= AEMPTY_L);
        o_len          = len;
        o_deq_rdy      = !o_empty;
        o_enq_rdy      = !o_full | i_deq_en;
        enq_acc        = i_enq_en & o_enq_rdy;
        deq_acc        = i_deq_en & !o_empty;
        o_out_data     = o_empty ? '1 : mem[tail];
    end

    // Next occupancy: simultaneous enqueue and dequeue leaves it unchanged.
    always_comb begin
        len_nxt = len;
        case ({enq_acc, deq_acc})
            2'b10:   len_nxt = len + 1'b1;
            2'b01:   len_nxt = len - 1'b1;
            default: len_nxt = len;
        endcase
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && enq_acc) begin
            mem[head] <= i_enq_data;
        end
    end

    // Pointers wrap explicitly so any depth works, and the occupancy register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head <= '0;
            tail <= '0;
            len  <= '0;
        end else begin
            if (enq_acc) head <= (head == LAST_ADDR) ? '0 : head + 1'b1;
            if (deq_acc) tail <= (tail == LAST_ADDR) ? '0 : tail + 1'b1;
            len <= len_nxt;
        end
    end

    // Sticky error flags (set beats clear) and the high-water mark.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_max_len   <= '0;
        end else begin
            if (i_enq_en && !enq_acc) o_overflow <= 1'b1;
            else if (i_clr_err)       o_overflow <= 1'b0;
            if (i_deq_en && o_empty)  o_underflow <= 1'b1;
            else if (i_clr_err)       o_underflow <= 1'b0;
            if (i_clr_err || (len_nxt > o_max_len)) o_max_len <= len_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_ext.sv
// Directed testbench for fifo_ext: default 8-deep instance plus a 5-deep instance
// exercising pointer wrap at a non-power-of-2 depth.
module tb_fifo_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: WL=8, SIZE=8, AF=6, AE=2
    logic       a_reset, a_enq_en, a_deq_en, a_clr;
    logic [7:0] a_enq_data, a_out;
    logic       a_enq_rdy, a_deq_rdy, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0] a_len, a_max;

    fifo_ext #(.p_WORD_LEN(8), .p_FIFO_SIZE(8), .p_AFULL_THRESH(6), .p_AEMPTY_THRESH(2)) dut_a (
        .i_clk(clk), .i_reset(a_reset), .i_enq_data(a_enq_data), .i_enq_en(a_enq_en),
        .o_enq_rdy(a_enq_rdy), .o_out_data(a_out), .i_deq_en(a_deq_en), .o_deq_rdy(a_deq_rdy),
        .o_full(a_full), .o_empty(a_empty), .o_almost_full(a_af), .o_almost_empty(a_ae),
        .o_len(a_len), .o_max_len(a_max), .o_overflow(a_ovf), .o_underflow(a_unf),
        .i_clr_err(a_clr)
    );

    // Instance B: WL=8, SIZE=5, AF=4, AE=1
    logic       b_reset, b_enq_en, b_deq_en, b_clr;
    logic [7:0] b_enq_data, b_out;
    logic       b_enq_rdy, b_deq_rdy, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_len, b_max;

    fifo_ext #(.p_WORD_LEN(8), .p_FIFO_SIZE(5), .p_AFULL_THRESH(4), .p_AEMPTY_THRESH(1)) dut_b (
        .i_clk(clk), .i_reset(b_reset), .i_enq_data(b_enq_data), .i_enq_en(b_enq_en),
        .o_enq_rdy(b_enq_rdy), .o_out_data(b_out), .i_deq_en(b_deq_en), .o_deq_rdy(b_deq_rdy),
        .o_full(b_full), .o_empty(b_empty), .o_almost_full(b_af), .o_almost_empty(b_ae),
        .o_len(b_len), .o_max_len(b_max), .o_overflow(b_ovf), .o_underflow(b_unf),
        .i_clr_err(b_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] drain_exp [8];
    logic [7:0] q [$];
    logic [1:0] ops [20];
    logic [7:0] b_word;

    initial begin
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hBB};
        // ops: bit1 = enqueue, bit0 = dequeue
        ops = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01};

        a_reset = 1'b1; a_enq_en = 1'b0; a_deq_en = 1'b0; a_clr = 1'b0; a_enq_data = '0;
        b_reset = 1'b1; b_enq_en = 1'b0; b_deq_en = 1'b0; b_clr = 1'b0; b_enq_data = '0;
        tick();
        a_reset = 1'b0; b_reset = 1'b0;
        #1;

        // Reset state
        chk("rst_len", a_len, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_ae", a_ae, 1);
        chk("rst_full", a_full, 0);
        chk("rst_af", a_af, 0);
        chk("rst_enq_rdy", a_enq_rdy, 1);
        chk("rst_deq_rdy", a_deq_rdy, 0);
        chk("rst_out", a_out, 8'hFF);
        chk("rst_max", a_max, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_unf", a_unf, 0);

        // 1. Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            a_enq_en = 1'b1; a_enq_data = 8'(i);
            tick();
            chk("fill_len", a_len, 32'(i));
            chk("fill_ae", a_ae, (i <= 2) ? 1 : 0);
            chk("fill_af", a_af, (i >= 6) ? 1 : 0);
            chk("fill_full", a_full, (i == 8) ? 1 : 0);
            chk("fill_out", a_out, 8'h01);
        end
        a_enq_en = 1'b0;
        chk("fill_max", a_max, 8);

        // 2. Enqueue on full without dequeue is rejected
        a_enq_en = 1'b1; a_enq_data = 8'hAA;
        #1;
        chk("full_enq_rdy", a_enq_rdy, 0);
        tick();
        chk("ovf_set", a_ovf, 1);
        chk("ovf_len", a_len, 8);
        chk("ovf_out", a_out, 8'h01);

        // Enqueue on full with dequeue: both accepted
        a_enq_data = 8'hBB; a_deq_en = 1'b1;
        #1;
        chk("full_deq_enq_rdy", a_enq_rdy, 1);
        tick();
        a_enq_en = 1'b0; a_deq_en = 1'b0;
        chk("both_len", a_len, 8);
        chk("both_full", a_full, 1);
        chk("both_out", a_out, 8'h02);

        // Drain: 0xBB must be the 8th word out
        for (int i = 0; i < 8; i++) begin
            chk("drain_out", a_out, drain_exp[i]);
            a_deq_en = 1'b1;
            tick();
        end
        a_deq_en = 1'b0;
        chk("drain_empty", a_empty, 1);
        chk("drain_unf", a_unf, 0);

        // 3. Dequeue on empty
        a_deq_en = 1'b1;
        tick();
        chk("unf_set", a_unf, 1);
        chk("unf_out", a_out, 8'hFF);
        chk("unf_len", a_len, 0);
        // Enqueue with dequeue on empty: enqueue only
        a_enq_en = 1'b1; a_enq_data = 8'h5A;
        tick();
        a_enq_en = 1'b0; a_deq_en = 1'b0;
        chk("nobyp_len", a_len, 1);
        chk("nobyp_out", a_out, 8'h5A);
        chk("nobyp_unf", a_unf, 1);

        // 5. Clear errors at len=3
        a_enq_en = 1'b1; a_enq_data = 8'h11;
        tick();
        a_enq_data = 8'h22;
        tick();
        a_enq_en = 1'b0;
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clr_len", a_len, 3);
        chk("clr_ovf", a_ovf, 0);
        chk("clr_unf", a_unf, 0);
        chk("clr_max", a_max, 3);
        // Fill to 8, then overflow coincident with clear: set wins
        a_enq_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_enq_data = 8'(8'h40 + i);
            tick();
        end
        chk("refill_len", a_len, 8);
        chk("refill_max", a_max, 8);
        a_enq_data = 8'hCC; a_clr = 1'b1;
        tick();
        a_enq_en = 1'b0; a_clr = 1'b0;
        chk("setwins_ovf", a_ovf, 1);
        chk("setwins_len", a_len, 8);
        chk("setwins_out", a_out, 8'h5A);

        // 6. Reset at len=4 with enqueue and dequeue active
        a_deq_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        a_deq_en = 1'b0;
        chk("pre_rst_len", a_len, 4);
        a_reset = 1'b1; a_enq_en = 1'b1; a_deq_en = 1'b1; a_enq_data = 8'h77;
        tick();
        a_reset = 1'b0; a_enq_en = 1'b0; a_deq_en = 1'b0;
        #1;
        chk("mid_rst_len", a_len, 0);
        chk("mid_rst_empty", a_empty, 1);
        chk("mid_rst_max", a_max, 0);
        chk("mid_rst_ovf", a_ovf, 0);
        chk("mid_rst_unf", a_unf, 0);
        chk("mid_rst_out", a_out, 8'hFF);
        chk("mid_rst_enq_rdy", a_enq_rdy, 1);

        // 4. SIZE=5 wrap sequence, occupancy walks 0..5 and back
        b_word = 8'h30;
        for (int i = 0; i < 20; i++) begin
            b_enq_en = ops[i][1];
            b_deq_en = ops[i][0];
            b_enq_data = b_word;
            #1;
            if (ops[i][0]) chk("b_out", b_out, q[0]);
            tick();
            if (ops[i][0]) void'(q.pop_front());
            if (ops[i][1]) begin
                q.push_back(b_word);
                b_word = b_word + 8'h01;
            end
            chk("b_len", b_len, q.size());
            chk("b_full", b_full, (q.size() == 5) ? 1 : 0);
        end
        b_enq_en = 1'b0; b_deq_en = 1'b0;
        chk("b_end_empty", b_empty, 1);
        chk("b_max", b_max, 5);
        chk("b_ovf", b_ovf, 0);
        chk("b_unf", b_unf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
